// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared constants, FSM state type and operand offset helper for the matmul engine
package simd_pkg;

    localparam int DEF_MATRIX_SIZE = 4;
    localparam int DEF_W_IN        = 8;
    localparam int DEF_N_PAIRS     = 4;

    function automatic int calc_w_out(input int ms, input int w_in);
        return 2 * w_in + $clog2(ms);
    endfunction

    localparam int DEF_W_OUT = calc_w_out(DEF_MATRIX_SIZE, DEF_W_IN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // mat: 0 = A (lower half of the pair slice), 1 = B (upper half)
    function automatic int elem_offset(input int pair, input int mat, input int r, input int c,
                                       input int ms, input int w);
        return ((pair * 2 + mat) * ms * ms + r * ms + c) * w;
    endfunction

endpackage

// File: rtl/row_dot_unit.sv
// rtl/row_dot_unit.sv - one result row: MS signed dot products of an A row against B's columns
module row_dot_unit #(
    parameter int MS    = 4,
    parameter int W_IN  = 8,
    parameter int W_OUT = 18
) (
    input  logic [MS*W_IN-1:0]    a_row_i,
    input  logic [MS*MS*W_IN-1:0] b_mat_i,
    output logic [MS*W_OUT-1:0]   c_row_o
);

    logic signed [2*W_IN-1:0] a_ext;
    logic signed [2*W_IN-1:0] b_ext;
    logic signed [2*W_IN-1:0] prod;
    logic signed [W_OUT-1:0]  acc;

    always_comb begin
        c_row_o = '0;
        a_ext   = '0;
        b_ext   = '0;
        prod    = '0;
        acc     = '0;
        for (int c = 0; c < MS; c++) begin
            acc = '0;
            for (int k = 0; k < MS; k++) begin
                // Operands widened first so the product keeps all 2*W_IN bits
                a_ext = (2*W_IN)'($signed(a_row_i[k*W_IN +: W_IN]));
                b_ext = (2*W_IN)'($signed(b_mat_i[(k*MS+c)*W_IN +: W_IN]));
                prod  = a_ext * b_ext;
                acc   = acc + W_OUT'(prod);
            end
            c_row_o[c*W_OUT +: W_OUT] = acc;
        end
    end

endmodule

// File: rtl/simd_matmul_engine.sv
// rtl/simd_matmul_engine.sv - captures a bundle of matrix pairs and computes each product one row per cycle
module simd_matmul_engine
    import simd_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int W_IN        = DEF_W_IN,
    parameter int N_PAIRS     = DEF_N_PAIRS
) (
    input  logic                                           ACLK,
    input  logic                                           ARESET,
    input  logic [N_PAIRS*2*MATRIX_SIZE*MATRIX_SIZE*W_IN-1:0] in_data,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    output logic [N_PAIRS*MATRIX_SIZE*MATRIX_SIZE*(2*W_IN+$clog2(MATRIX_SIZE))-1:0] out_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic                                           busy
);

    localparam int MS    = MATRIX_SIZE;
    localparam int W_OUT = 2 * W_IN + $clog2(MATRIX_SIZE);
    localparam int IN_W  = N_PAIRS * 2 * MS * MS * W_IN;
    localparam int OUT_W = N_PAIRS * MS * MS * W_OUT;
    localparam int RW    = (MS > 1) ? $clog2(MS) : 1;
    localparam int PW    = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

    state_e state_q, state_d;

    logic [IN_W-1:0]  op_buf_q, op_buf_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PW-1:0]    pair_q, pair_d;
    logic             out_valid_q, out_valid_d;

    logic [MS*W_IN-1:0]    a_row;
    logic [MS*MS*W_IN-1:0] b_mat;
    logic [MS*W_OUT-1:0]   c_row;
    int                    a_base, b_base, c_base;
    logic                  last_row, last_pair, accept;

    assign last_row  = (row_q == RW'(MS - 1));
    assign last_pair = (pair_q == PW'(N_PAIRS - 1));
    assign accept    = in_valid && in_ready;

    always_comb begin
        a_base = elem_offset(int'(pair_q), 0, int'(row_q), 0, MS, W_IN);
        b_base = elem_offset(int'(pair_q), 1, 0, 0, MS, W_IN);
        c_base = (int'(pair_q) * MS + int'(row_q)) * MS * W_OUT;
        a_row  = op_buf_q[a_base +: MS*W_IN];
        b_mat  = op_buf_q[b_base +: MS*MS*W_IN];
    end

    row_dot_unit #(
        .MS    (MS),
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) u_row_dot (
        .a_row_i (a_row),
        .b_mat_i (b_mat),
        .c_row_o (c_row)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = COMPUTE;
            COMPUTE: if (last_row && last_pair) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && !ARESET;
        busy     = (state_q != IDLE);
    end

    always_comb begin
        op_buf_d    = op_buf_q;
        out_data_d  = out_data_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_buf_d = in_data;
                    row_d    = '0;
                    pair_d   = '0;
                end
            end
            COMPUTE: begin
                out_data_d[c_base +: MS*W_OUT] = c_row;
                if (last_row) begin
                    row_d  = '0;
                    pair_d = pair_q + PW'(1);
                    if (last_pair) out_valid_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            op_buf_q    <= '0;
            out_data_q  <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            op_buf_q    <= op_buf_d;
            out_data_q  <= out_data_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
